// File: rtl/rep_enc_if.sv
// Serial bit interface of the repetition encoder: input bit stream in,
// repeated bit stream plus busy/overflow status out.
interface rep_enc_if;
  logic i_di;
  logic i_di_vld;
  logic o_busy;
  logic o_ovf;
  logic o_do;
  logic o_do_vld;

  modport master (
    output i_di, i_di_vld,
    input  o_busy, o_ovf, o_do, o_do_vld
  );

  modport slave (
    input  i_di, i_di_vld,
    output o_busy, o_ovf, o_do, o_do_vld
  );
endinterface

// File: rtl/rep_enc.sv
// Block repetition encoder: buffers BLK_LEN input bits, then emits the whole
// block REP times back-to-back so bit k lands at k, k+BLK_LEN, ... .
module rep_enc #(
  parameter int BLK_LEN = 96,
  parameter int REP     = 10
) (
  input logic      clk,
  input logic      rst,
  rep_enc_if.slave bus
);
  localparam int AW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam int RW = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(BLK_LEN - 1);
  localparam logic [RW-1:0] LAST_REP = RW'(REP - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FULL = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_idx;
  logic [RW-1:0] r_rep_cnt;
  logic          r_buf [BLK_LEN];
  logic          r_do;
  logic          r_do_vld;
  logic          r_busy;
  logic          r_ovf;

  state_t        w_state_nxt;
  logic [AW-1:0] w_wr_cnt_nxt;
  logic [AW-1:0] w_rd_idx_nxt;
  logic [RW-1:0] w_rep_cnt_nxt;
  logic          w_do_nxt;
  logic          w_do_vld_nxt;
  logic          w_ovf_nxt;
  logic          w_wr_en;

  // The first bit is registered on the FULL->EMIT edge, so do_vld appears
  // two edges after the last input bit and busy drops with the final bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_cnt_nxt  = r_wr_cnt;
    w_rd_idx_nxt  = r_rd_idx;
    w_rep_cnt_nxt = r_rep_cnt;
    w_do_nxt      = 1'b0;
    w_do_vld_nxt  = 1'b0;
    w_ovf_nxt     = 1'b0;
    w_wr_en       = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (bus.i_di_vld) begin
          w_wr_en = 1'b1;
          if (r_wr_cnt == LAST_IDX) begin
            w_wr_cnt_nxt  = {AW{1'b0}};
            w_rd_idx_nxt  = {AW{1'b0}};
            w_rep_cnt_nxt = {RW{1'b0}};
            w_state_nxt   = S_FULL;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + AW'(1);
          end
        end else begin
          w_wr_cnt_nxt = r_wr_cnt;
        end
      end
      S_FULL, S_EMIT: begin
        w_ovf_nxt    = bus.i_di_vld;
        w_do_nxt     = r_buf[r_rd_idx];
        w_do_vld_nxt = 1'b1;
        w_state_nxt  = S_EMIT;
        if (r_rd_idx == LAST_IDX) begin
          w_rd_idx_nxt = {AW{1'b0}};
          if (r_rep_cnt == LAST_REP) begin
            w_rep_cnt_nxt = {RW{1'b0}};
            w_state_nxt   = S_LOAD;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + RW'(1);
          end
        end else begin
          w_rd_idx_nxt = r_rd_idx + AW'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_LOAD;
      r_wr_cnt  <= {AW{1'b0}};
      r_rd_idx  <= {AW{1'b0}};
      r_rep_cnt <= {RW{1'b0}};
      r_do      <= 1'b0;
      r_do_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_do      <= w_do_nxt;
      r_do_vld  <= w_do_vld_nxt;
      r_busy    <= (w_state_nxt != S_LOAD);
      r_ovf     <= w_ovf_nxt;
    end
  end

  // Block buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_cnt] <= bus.i_di;
    end
  end

  assign bus.o_do     = r_do;
  assign bus.o_do_vld = r_do_vld;
  assign bus.o_busy   = r_busy;
  assign bus.o_ovf    = r_ovf;
endmodule

// File: doc/rep_enc.md
Name: rep_enc

Overview:
- Transmit-side counterpart of the receiver's 10x majority-vote mean block.
- Collects one block of BLK_LEN serial data bits into an internal buffer.
- Emits the whole block REP times back-to-back, so bit k appears at output positions k, k+BLK_LEN, ..., k+(REP-1)*BLK_LEN, which is the order the receiver de-repeats.
- Sits between the transmit bit source and the constellation mapper.

Parameters:
- BLK_LEN, 96: bits per block (buffer depth).
- REP, 10: repetitions per block; total output bits = BLK_LEN*REP (960 at defaults).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- di  in  1  serial input data bit.
- di_vld  in  1  di is valid this cycle.
- busy  out  1  high while the block is not accepting input (FULL/EMIT).
- ovf  out  1  one-cycle pulse: di_vld was asserted while busy=1 and that bit was dropped.
- do  out  1  serial repeated output bit.
- do_vld  out  1  do is valid this cycle.

Behaviour:
- Reset: rst sampled high at a rising edge clears do, do_vld, busy, ovf, all counters and the state (to LOAD) in the same edge. Buffer contents are don't-care. A partial or in-flight block is discarded with no further do_vld.
- Counters:
  - wr_cnt: 0..BLK_LEN-1.
  - rd_idx: 0..BLK_LEN-1.
  - rep_cnt: 0..REP-1.
  - Widths are $clog2 of the range; no wrap outside these ranges.
- State LOAD (busy=0):
  - Each cycle with di_vld=1: buf[wr_cnt] <= di, wr_cnt++.
  - Gaps in di_vld are allowed; wr_cnt holds. There is no timeout.
  - When a bit is written with wr_cnt==BLK_LEN-1: wr_cnt<=0, state<=FULL.
- State FULL (busy=1): one cycle; sets rd_idx=0 and rep_cnt=0, then state<=EMIT.
- State EMIT (busy=1):
  - Each cycle: do<=buf[rd_idx], do_vld<=1 (registered), rd_idx++.
  - At rd_idx==BLK_LEN-1: rd_idx<=0, rep_cnt++.
  - When rd_idx==BLK_LEN-1 and rep_cnt==REP-1: the last bit is issued and state<=LOAD.
- Latency and timing, with the last input bit sampled at edge t:
  - busy=1 from t+1.
  - First do_vld at t+2.
  - do_vld stays high for exactly BLK_LEN*REP consecutive cycles (t+2..t+961 at defaults).
  - busy=0 at t+961, so a new bit can be accepted at edge t+961. Its output is not affected by the current emission.
  - do_vld=0 at t+962 unless a new block has completed.
- Outputs when invalid: do=0 whenever do_vld=0.
- Overflow: di_vld=1 while busy=1 means the bit is dropped, the buffer and wr_cnt are unchanged, and ovf=1 on the next cycle. Otherwise ovf=0.
- Buffer: inferred register array BLK_LEN x 1. Write and read never target the same block concurrently, so no bypass is needed.
- No backpressure from downstream: the consumer must accept one bit per cycle while do_vld=1.

Test Plan:
- Reset, then 96 contiguous bits of pattern b[k]=k[0]^k[3]. Required:
  - busy rises 1 cycle after the last bit.
  - do_vld rises 2 cycles after the last bit.
  - 960 contiguous valid bits where out[j]==b[j mod 96].
  - do_vld and busy fall as timed above.
- Input with random di_vld gaps (50% duty) until 96 bits are accepted -> output identical to the gap-free case; no emission before the 96th bit.
- di_vld held high through the whole emission (bits 96..1100) -> every bit while busy=1 is dropped with a one-cycle-delayed ovf pulse each. The output block is unchanged. The bit presented at the cycle busy falls starts the next block, with wr_cnt=1 after it.
- Two back-to-back blocks (all-ones, then all-zeros, the second presented as soon as busy=0) -> 960 ones followed by 960 zeros. Exactly 1920 do_vld cycles in total, no ovf.
- rst asserted for one cycle mid-emission (after 400 output bits) -> do_vld=0 and busy=0 from the next cycle. A following fresh 96-bit block is emitted correctly with no residue.
- rst asserted after 50 of 96 input bits, then 96 new bits -> the output contains only the new 96-bit block repeated 10 times.
